// File: rtl/ray_column_gen_pkg.sv
`timescale 1ns/1ps
// Shared types, constants and the ray-direction adder for the ray column generator.
// Build option: define RAYGEN_SAT_EN to saturate ray direction sums instead of wrapping them.
package raycast_pkg;

    typedef logic signed [15:0] fp16_t;

    localparam int    FP_FRAC = 8;
    localparam fp16_t FP_ONE  = 16'h0100;

    // Camera accumulator: Q8.16, so its [23:8] slice is cameraX in Q8.8 (floor shift).
    localparam int CAM_W = 24;
    typedef logic signed [CAM_W-1:0] cam_t;
    localparam cam_t CAM_START = -24'sd65536;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_SUM,
        S_OUT
    } state_t;

    // dir + prod[23:8]; the mid slice is the Q8.8 product of plane and cameraX.
    function automatic fp16_t ray_dir_sum(input fp16_t dir, input fp16_t prod_mid);
`ifdef RAYGEN_SAT_EN
        logic signed [16:0] sum;
        sum = {dir[15], dir} + {prod_mid[15], prod_mid};
        if (sum[16] != sum[15]) begin
            return sum[16] ? 16'sh8000 : 16'sh7FFF;
        end
        return sum[15:0];
`else
        return dir + prod_mid;
`endif
    endfunction

endpackage

// File: rtl/ray_column_gen_if.sv
`timescale 1ns/1ps
// Ray stream from the column generator to the DDA wall-stepper (valid/ready handshake).
interface ray_column_gen_if #(
    parameter int COL_W = 9
);
    import raycast_pkg::*;

    logic             ray_valid;
    logic             ray_ready;
    logic [COL_W-1:0] ray_col;
    fp16_t            ray_posX;
    fp16_t            ray_posY;
    fp16_t            rayDirX;
    fp16_t            rayDirY;
    logic             ray_last;

    modport master (
        output ray_valid, ray_col, ray_posX, ray_posY, rayDirX, rayDirY, ray_last,
        input  ray_ready
    );

    modport slave (
        input  ray_valid, ray_col, ray_posX, ray_posY, rayDirX, rayDirY, ray_last,
        output ray_ready
    );

endinterface

// File: rtl/fp_mul_q88.sv
`timescale 1ns/1ps
// Registered signed 16x16 multiply with a full 32-bit product; loads only when en is high.
module fp_mul_q88
    import raycast_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               en,
    input  fp16_t              a,
    input  fp16_t              b,
    output logic signed [31:0] p
);

    // NOTE: sequential state is written with non-blocking (<=) assignments so every
    // register samples the values from before the clock edge, independent of block order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            p <= '0;
        end else if (en) begin
            p <= 32'(a) * 32'(b);
        end
    end

endmodule

// File: rtl/ray_column_gen.sv
`timescale 1ns/1ps
// Once per frame, snapshots the player state and streams one ray per screen column, 0..SCREEN_W-1.
// Build option RAYGEN_SAT_EN (raycast_pkg) selects saturating instead of wrapping direction sums.
module ray_column_gen
    import raycast_pkg::*;
#(
    parameter int  SCREEN_W = 320,
    parameter int  CAM_STEP = (2**17) / SCREEN_W,
    localparam int COL_W    = $clog2(SCREEN_W)
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  frame_start,
    input  fp16_t posX,
    input  fp16_t posY,
    input  fp16_t dirX,
    input  fp16_t dirY,
    input  fp16_t planeX,
    input  fp16_t planeY,
    output logic  busy,
    output logic  frame_done,
    ray_column_gen_if.master ray
);

    state_t             state;
    logic [COL_W-1:0]   col;
    cam_t               cam_acc;
    fp16_t              snap_pos_x, snap_pos_y;
    fp16_t              snap_dir_x, snap_dir_y;
    fp16_t              snap_plane_x, snap_plane_y;
    fp16_t              ray_dir_x, ray_dir_y;
    logic               ray_valid;
    logic               ray_last;
    fp16_t              cam_x;
    logic               mul_en;
    logic               is_last_col;
    logic signed [31:0] prod_x, prod_y;
    logic               unused_prod_bits;

    assign cam_x       = cam_acc[FP_FRAC+15:FP_FRAC];
    assign mul_en      = (state == S_MUL);
    assign is_last_col = (col == COL_W'(SCREEN_W - 1));

    // Only the Q8.8 middle slice of each product feeds the ray direction.
    assign unused_prod_bits = ^{prod_x[31:24], prod_x[7:0], prod_y[31:24], prod_y[7:0]};

    fp_mul_q88 u_mul_x (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (mul_en),
        .a      (snap_plane_x),
        .b      (cam_x),
        .p      (prod_x)
    );

    fp_mul_q88 u_mul_y (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (mul_en),
        .a      (snap_plane_y),
        .b      (cam_x),
        .p      (prod_y)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= S_IDLE;
            col          <= '0;
            cam_acc      <= CAM_START;
            snap_pos_x   <= '0;
            snap_pos_y   <= '0;
            snap_dir_x   <= '0;
            snap_dir_y   <= '0;
            snap_plane_x <= '0;
            snap_plane_y <= '0;
            ray_dir_x    <= '0;
            ray_dir_y    <= '0;
            ray_valid    <= 1'b0;
            ray_last     <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // NOTE: the default arm makes the case complete; registers simply hold otherwise.
            unique case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        snap_pos_x   <= posX;
                        snap_pos_y   <= posY;
                        snap_dir_x   <= dirX;
                        snap_dir_y   <= dirY;
                        snap_plane_x <= planeX;
                        snap_plane_y <= planeY;
                        col          <= '0;
                        cam_acc      <= CAM_START;
                        busy         <= 1'b1;
                        state        <= S_MUL;
                    end
                end
                S_MUL: begin
                    state <= S_SUM;
                end
                S_SUM: begin
                    ray_dir_x <= ray_dir_sum(snap_dir_x, prod_x[23:8]);
                    ray_dir_y <= ray_dir_sum(snap_dir_y, prod_y[23:8]);
                    ray_last  <= is_last_col;
                    ray_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    // frame_start is not looked at here, so a pulse on the last accept is dropped.
                    if (ray.ray_ready) begin
                        ray_valid <= 1'b0;
                        ray_last  <= 1'b0;
                        if (is_last_col) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            col     <= col + 1'b1;
                            cam_acc <= cam_acc + cam_t'(CAM_STEP);
                            state   <= S_MUL;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ray.ray_valid = ray_valid;
    assign ray.ray_col   = col;
    assign ray.ray_posX  = snap_pos_x;
    assign ray.ray_posY  = snap_pos_y;
    assign ray.rayDirX   = ray_dir_x;
    assign ray.rayDirY   = ray_dir_y;
    assign ray.ray_last  = ray_last;

endmodule

// File: tb/tb_ray_column_gen.sv
`timescale 1ns/1ps
// Scoreboard bench for ray_column_gen: a frame's expected rays are queued when it is started
// and popped as the DUT transfers them.
module tb_ray_column_gen;
    import raycast_pkg::*;

    localparam int SCREEN_W = 320;
    localparam int CAM_STEP = (2**17) / SCREEN_W;
    localparam int COL_W    = $clog2(SCREEN_W);
`ifdef RAYGEN_SAT_EN
    localparam logic [31:0] T4_EXP_DIRX = 32'h7FFF;
`else
    localparam logic [31:0] T4_EXP_DIRX = 32'hFC83;
`endif

    typedef struct {
        int    col;
        fp16_t dx;
        fp16_t dy;
        fp16_t px;
        fp16_t py;
        logic  last;
    } ray_t;

    logic  clk_in      = 1'b0;
    logic  rst_in      = 1'b1;
    logic  frame_start = 1'b0;
    fp16_t pos_x = '0, pos_y = '0, dir_x = '0, dir_y = '0, plane_x = '0, plane_y = '0;
    logic  busy, frame_done;

    ray_column_gen_if #(.COL_W(COL_W)) ray ();

    ray_column_gen #(.SCREEN_W(SCREEN_W)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .frame_start (frame_start),
        .posX        (pos_x),
        .posY        (pos_y),
        .dirX        (dir_x),
        .dirY        (dir_y),
        .planeX      (plane_x),
        .planeY      (plane_y),
        .busy        (busy),
        .frame_done  (frame_done),
        .ray         (ray)
    );

    always #5 clk_in = ~clk_in;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ray_t sb[$];
    int   n_xfer = 0, n_done = 0;
    int   xfer_base = 0, done_base = 0;
    int   start_cyc = 0, done_cyc = 0;
    int   first_valid_cyc = -1, last_xfer_cyc = -1;
    bit   t1_mode = 0, t4_mode = 0, spacing_mode = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] u16(input fp16_t v);
        return {16'h0000, v};
    endfunction

    function automatic fp16_t model_sum(input fp16_t d, input int prod);
        int    s;
        fp16_t mid;
        mid = fp16_t'(prod >>> 8);
        s   = int'(d) + int'(mid);
`ifdef RAYGEN_SAT_EN
        if (s > 32767)  return 16'sh7FFF;
        if (s < -32768) return 16'sh8000;
`endif
        return fp16_t'(s);
    endfunction

    function automatic ray_t model_ray(input int c, input fp16_t px, input fp16_t py,
                                       input fp16_t dx, input fp16_t dy,
                                       input fp16_t plx, input fp16_t ply);
        ray_t  r;
        int    acc;
        fp16_t camx;
        acc    = -65536 + c * CAM_STEP;
        camx   = fp16_t'(acc >>> 8);
        r.col  = c;
        r.px   = px;
        r.py   = py;
        r.dx   = model_sum(dx, int'(plx) * int'(camx));
        r.dy   = model_sum(dy, int'(ply) * int'(camx));
        r.last = (c == SCREEN_W - 1);
        return r;
    endfunction

    // Transfer monitor, sampled mid-way through the low clock phase.
    always begin : monitor
        ray_t e;
        @(negedge clk_in);
        #2;
        if (!rst_in) begin
            if (first_valid_cyc < 0 && ray.ray_valid) first_valid_cyc = cyc;
            if (ray.ray_valid && ray.ray_ready) begin
                n_xfer++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ray_col",  32'(ray.ray_col), e.col);
                    check("ray_dirx", u16(ray.rayDirX), u16(e.dx));
                    check("ray_diry", u16(ray.rayDirY), u16(e.dy));
                    check("ray_posx", u16(ray.ray_posX), u16(e.px));
                    check("ray_posy", u16(ray.ray_posY), u16(e.py));
                    check("ray_last", 32'(ray.ray_last), 32'(e.last));
                    if (t1_mode && e.col == 0) begin
                        check("t1_c0_dirx", u16(ray.rayDirX), 32'h0100);
                        check("t1_c0_diry", u16(ray.rayDirY), 32'hFF57);
                        check("t1_c0_posx", u16(ray.ray_posX), 32'h0380);
                        check("t1_c0_posy", u16(ray.ray_posY), 32'h0240);
                    end
                    if (t1_mode && e.col == 160) check("t1_c160_diry", u16(ray.rayDirY), 32'hFFFF);
                    if (t1_mode && e.col == SCREEN_W - 1) begin
                        check("t1_c319_diry", u16(ray.rayDirY), 32'h00A7);
                        check("t1_c319_last", 32'(ray.ray_last), 32'd1);
                    end
                    if (t4_mode && e.col == SCREEN_W - 1)
                        check("t4_c319_dirx", u16(ray.rayDirX), T4_EXP_DIRX);
                end
                if (spacing_mode && last_xfer_cyc >= 0)
                    check("xfer_spacing", cyc - last_xfer_cyc, 32'd3);
                last_xfer_cyc = cyc;
            end
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_frame(input fp16_t px, input fp16_t py, input fp16_t dx,
                               input fp16_t dy, input fp16_t plx, input fp16_t ply);
        @(negedge clk_in);
        pos_x = px; pos_y = py; dir_x = dx; dir_y = dy; plane_x = plx; plane_y = ply;
        frame_start = 1'b1;
        for (int c = 0; c < SCREEN_W; c++) sb.push_back(model_ray(c, px, py, dx, dy, plx, ply));
        start_cyc       = cyc;
        xfer_base       = n_xfer;
        done_base       = n_done;
        first_valid_cyc = -1;
        last_xfer_cyc   = -1;
        @(negedge clk_in);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (n_done == done_base && n < 4000) begin
            @(negedge clk_in);
            #3;
            n++;
        end
        check({tag, "_done_seen"}, 32'(n_done != done_base), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk_in);
        #3;
        check({tag, "_xfers"}, n_xfer - xfer_base, SCREEN_W);
        check({tag, "_done_cnt"}, n_done - done_base, 32'd1);
        check({tag, "_sb_left"}, sb.size(), 32'd0);
    endtask

    task automatic wait_col(input int c, input string tag);
        int n = 0;
        do begin
            @(negedge clk_in);
            #1;
            n++;
        end while (!(ray.ray_col == COL_W'(c) && busy) && n < 4000);
        check(tag, 32'(ray.ray_col == COL_W'(c) && busy), 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        ray_t exp_r;
        int   n;
        ray.ray_ready = 1'b0;

        // Reset state
        #1;
        check("rst_valid", 32'(ray.ray_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(frame_done), 32'd0);
        check("rst_col",   32'(ray.ray_col), 32'd0);
        check("rst_dirx",  u16(ray.rayDirX), 32'd0);
        check("rst_posy",  u16(ray.ray_posY), 32'd0);
        check("rst_last",  32'(ray.ray_last), 32'd0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;

        // T1 / T6: nominal frame, ready always high
        ray.ray_ready = 1'b1;
        t1_mode = 1; spacing_mode = 1;
        start_frame(16'h0380, 16'h0240, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
        wait_done("t1");
        check("t6_first_valid_lat", first_valid_cyc - start_cyc, 32'd3);
        check("t6_frame_len", done_cyc - start_cyc - 1, 32'd960);
        t1_mode = 0; spacing_mode = 0;

        // T2: backpressure on column 3
        start_frame(16'h1000, 16'h0A00, 16'h00B5, 16'h00B5, 16'hFF88, 16'h0078);
        wait_col(3, "t2_reach_col3");
        ray.ray_ready = 1'b0;
        n = 0;
        while (!ray.ray_valid && n < 10) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        exp_r = model_ray(3, 16'h1000, 16'h0A00, 16'h00B5, 16'h00B5, 16'hFF88, 16'h0078);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            #1;
            check("t2_hold_valid", 32'(ray.ray_valid), 32'd1);
            check("t2_hold_col",   32'(ray.ray_col), 32'd3);
            check("t2_hold_dirx",  u16(ray.rayDirX), u16(exp_r.dx));
            check("t2_hold_diry",  u16(ray.rayDirY), u16(exp_r.dy));
        end
        ray.ray_ready = 1'b1;
        wait_done("t2");

        // T3: mid-frame input change and frame_start are invisible; pulse on last accept ignored
        start_frame(16'h0200, 16'h0300, 16'hFF00, 16'h0040, 16'h0054, 16'hFFAC);
        wait_col(100, "t3_reach_col100");
        dir_x = 16'h1234; dir_y = 16'h4321; plane_x = 16'h7000; plane_y = 16'h0F0F;
        pos_x = 16'h0101; pos_y = 16'h0202;
        frame_start = 1'b1;
        @(negedge clk_in);
        frame_start = 1'b0;
        n = 0;
        do begin
            @(negedge clk_in);
            #1;
            n++;
        end while (!(ray.ray_valid && ray.ray_last) && n < 4000);
        check("t3_last_seen", 32'(ray.ray_valid && ray.ray_last), 32'd1);
        frame_start = 1'b1;
        @(negedge clk_in);
        frame_start = 1'b0;
        #3;
        check("t3_busy_after_last", 32'(busy), 32'd0);
        repeat (4) @(negedge clk_in);
        #3;
        check("t3_busy_stays_low", 32'(busy), 32'd0);
        check("t3_valid_stays_low", 32'(ray.ray_valid), 32'd0);
        check("t3_xfers", n_xfer - xfer_base, SCREEN_W);
        check("t3_done_cnt", n_done - done_base, 32'd1);
        check("t3_sb_left", sb.size(), 32'd0);

        // T4: wrap vs saturate on the last column
        t4_mode = 1;
        start_frame(16'h0000, 16'h0000, 16'h7F00, 16'h0000, 16'h7F00, 16'h0000);
        wait_done("t4");
        t4_mode = 0;

        // T5: asynchronous reset mid-frame, then a clean restart
        start_frame(16'h0380, 16'h0240, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
        wait_col(50, "t5_reach_col50");
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        check("t5_rst_valid", 32'(ray.ray_valid), 32'd0);
        check("t5_rst_busy",  32'(busy), 32'd0);
        check("t5_rst_col",   32'(ray.ray_col), 32'd0);
        check("t5_rst_dirx",  u16(ray.rayDirX), 32'd0);
        check("t5_rst_diry",  u16(ray.rayDirY), 32'd0);
        check("t5_rst_posx",  u16(ray.ray_posX), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        t1_mode = 1; spacing_mode = 1;
        start_frame(16'h0380, 16'h0240, 16'h0100, 16'h0000, 16'h0000, 16'h00A9);
        wait_done("t5");
        check("t5_first_valid_lat", first_valid_cyc - start_cyc, 32'd3);
        t1_mode = 0; spacing_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
